// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: datapath words, register/CSR addresses,
// load size encodings, FSM state encodings and the latched W-register record.
package writeback_stage_pkg;

    localparam int unsigned XLEN = 64;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [4:0]      creg_addr_t;
    typedef logic [11:0]     u12;
    typedef logic [1:0]      mem_size_t;

    localparam mem_size_t MEM_B = 2'd0;
    localparam mem_size_t MEM_H = 2'd1;
    localparam mem_size_t MEM_W = 2'd2;
    localparam mem_size_t MEM_D = 2'd3;

    typedef logic [1:0] wb_state_t;

    localparam wb_state_t ST_RUN   = 2'd0;
    localparam wb_state_t ST_FLUSH = 2'd1;
    localparam wb_state_t ST_HALT  = 2'd2;

    typedef struct packed {
        word_t       pc;
        logic [31:0] instr;
        creg_addr_t  dst;
        logic        rf_wen;
        word_t       result;
        logic        is_load;
        mem_size_t   mem_size;
        logic        mem_unsigned;
        logic [2:0]  mem_addr_lo;
        word_t       mem_rdata;
        logic        csr_wen;
        u12          csr_addr;
        word_t       csr_wdata;
        logic        trap;
        logic        halt;
    } writeback_data_t;

    // Bit shift that brings the addressed byte of a 64-bit word down to bit 0.
    function automatic logic [5:0] byte_shift(input logic [2:0] addr_lo);
        return {addr_lo, 3'b000};
    endfunction

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load alignment: shifts the addressed bytes down and sign- or
// zero-extends them to a full word according to the access size.
module writeback_stage_load_extend
    import writeback_stage_pkg::*;
(
    input  word_t      rdata,
    input  logic [2:0] addr_lo,
    input  mem_size_t  size,
    input  logic       mem_unsigned,
    output word_t      data
);

    word_t shifted;
    logic  sign_b;
    logic  sign_h;
    logic  sign_w;

    always_comb begin
        // Bytes shifted past bit 63 fall off and read back as zero.
        shifted = rdata >> byte_shift(addr_lo);
        sign_b  = !mem_unsigned && shifted[7];
        sign_h  = !mem_unsigned && shifted[15];
        sign_w  = !mem_unsigned && shifted[31];
        data    = shifted;
        case (size)
            MEM_B:   data = {{56{sign_b}}, shifted[7:0]};
            MEM_H:   data = {{48{sign_h}}, shifted[15:0]};
            MEM_W:   data = {{32{sign_w}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: holds one instruction, drives the GPR and CSR write ports,
// reports commits and bypass data, sequences trap flush / halt, and keeps mcycle/minstret.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter u12 MCYCLE_ADDR   = 12'hB00,
    parameter u12 MINSTRET_ADDR = 12'hB02
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  word_t       in_pc,
    input  logic [31:0] in_instr,
    input  creg_addr_t  in_dst,
    input  logic        in_rf_wen,
    input  word_t       in_result,
    input  logic        in_is_load,
    input  mem_size_t   in_mem_size,
    input  logic        in_mem_unsigned,
    input  logic [2:0]  in_mem_addr_lo,
    input  word_t       in_mem_rdata,
    input  logic        in_csr_wen,
    input  u12          in_csr_addr,
    input  word_t       in_csr_wdata,
    input  logic        in_trap,
    input  logic        in_halt,
    input  logic        stall,
    output logic        wen,
    output creg_addr_t  wa,
    output word_t       wd,
    output logic        csr_wen,
    output u12          csr_wa,
    output word_t       csr_wd,
    output logic        commit_valid,
    output word_t       commit_pc,
    output logic [31:0] commit_instr,
    output logic        fwd_valid,
    output creg_addr_t  fwd_dst,
    output word_t       fwd_data,
    output logic        flush,
    output logic        halted,
    output word_t       mcycle,
    output word_t       minstret
);

    writeback_data_t w_q, w_d;
    logic            w_valid_q, w_valid_d;
    wb_state_t       state_q, state_d;
    word_t           mcycle_q, mcycle_d;
    word_t           minstret_q, minstret_d;

    logic            commit;
    logic            accept;
    logic            gpr_ok;
    word_t           load_data;

    writeback_stage_load_extend u_load_extend (
        .rdata        (w_q.mem_rdata),
        .addr_lo      (w_q.mem_addr_lo),
        .size         (w_q.mem_size),
        .mem_unsigned (w_q.mem_unsigned),
        .data         (load_data)
    );

    always_comb begin
        commit   = w_valid_q && !stall && (state_q == ST_RUN);
        in_ready = (state_q == ST_RUN) && (!w_valid_q || !stall);
        accept   = in_valid && in_ready;
        gpr_ok   = w_q.rf_wen && (w_q.dst != 5'd0) && !w_q.trap;

        wen          = commit && gpr_ok;
        wa           = w_q.dst;
        wd           = w_q.is_load ? load_data : w_q.result;
        csr_wen      = commit && w_q.csr_wen && !w_q.trap;
        csr_wa       = w_q.csr_addr;
        csr_wd       = w_q.csr_wdata;
        commit_valid = commit;
        commit_pc    = w_q.pc;
        commit_instr = w_q.instr;
        fwd_valid    = w_valid_q && gpr_ok;
        fwd_dst      = w_q.dst;
        fwd_data     = wd;
        flush        = (state_q == ST_FLUSH);
        halted       = (state_q == ST_HALT);
        mcycle       = mcycle_q;
        minstret     = minstret_q;
    end

    always_comb begin
        w_d = w_q;
        if (accept) begin
            w_d.pc           = in_pc;
            w_d.instr        = in_instr;
            w_d.dst          = in_dst;
            w_d.rf_wen       = in_rf_wen;
            w_d.result       = in_result;
            w_d.is_load      = in_is_load;
            w_d.mem_size     = in_mem_size;
            w_d.mem_unsigned = in_mem_unsigned;
            w_d.mem_addr_lo  = in_mem_addr_lo;
            w_d.mem_rdata    = in_mem_rdata;
            w_d.csr_wen      = in_csr_wen;
            w_d.csr_addr     = in_csr_addr;
            w_d.csr_wdata    = in_csr_wdata;
            w_d.trap         = in_trap;
            w_d.halt         = in_halt;
        end

        // Anything picked up alongside a trap commit is thrown away in the flush cycle.
        if (state_q == ST_FLUSH) begin
            w_valid_d = 1'b0;
        end else if (accept) begin
            w_valid_d = 1'b1;
        end else if (commit) begin
            w_valid_d = 1'b0;
        end else begin
            w_valid_d = w_valid_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (commit && w_q.trap) begin
                    state_d = ST_FLUSH;
                end else if (commit && w_q.halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_FLUSH: state_d = ST_RUN;
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, commit};
        // A CSR write to a counter takes precedence over its increment.
        if (csr_wen && (csr_wa == MCYCLE_ADDR)) begin
            mcycle_d = csr_wd;
        end
        if (csr_wen && (csr_wa == MINSTRET_ADDR)) begin
            minstret_d = csr_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_q        <= '0;
            w_valid_q  <= 1'b0;
            state_q    <= ST_RUN;
            mcycle_q   <= '0;
            minstret_q <= '0;
        end else begin
            w_q        <= w_d;
            w_valid_q  <= w_valid_d;
            state_q    <= state_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
// Directed, table-driven bench for writeback_stage: a vector table for single
// instructions plus hand-written sequences for stall, back-to-back, CSR, trap, halt, reset.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_pc;
    logic [31:0] in_instr;
    logic [4:0]  in_dst;
    logic        in_rf_wen;
    logic [63:0] in_result;
    logic        in_is_load;
    logic [1:0]  in_mem_size;
    logic        in_mem_unsigned;
    logic [2:0]  in_mem_addr_lo;
    logic [63:0] in_mem_rdata;
    logic        in_csr_wen;
    logic [11:0] in_csr_addr;
    logic [63:0] in_csr_wdata;
    logic        in_trap;
    logic        in_halt;
    logic        stall;
    logic        wen;
    logic [4:0]  wa;
    logic [63:0] wd;
    logic        csr_wen;
    logic [11:0] csr_wa;
    logic [63:0] csr_wd;
    logic        commit_valid;
    logic [63:0] commit_pc;
    logic [31:0] commit_instr;
    logic        fwd_valid;
    logic [4:0]  fwd_dst;
    logic [63:0] fwd_data;
    logic        flush;
    logic        halted;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    writeback_stage dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_instr        (in_instr),
        .in_dst          (in_dst),
        .in_rf_wen       (in_rf_wen),
        .in_result       (in_result),
        .in_is_load      (in_is_load),
        .in_mem_size     (in_mem_size),
        .in_mem_unsigned (in_mem_unsigned),
        .in_mem_addr_lo  (in_mem_addr_lo),
        .in_mem_rdata    (in_mem_rdata),
        .in_csr_wen      (in_csr_wen),
        .in_csr_addr     (in_csr_addr),
        .in_csr_wdata    (in_csr_wdata),
        .in_trap         (in_trap),
        .in_halt         (in_halt),
        .stall           (stall),
        .wen             (wen),
        .wa              (wa),
        .wd              (wd),
        .csr_wen         (csr_wen),
        .csr_wa          (csr_wa),
        .csr_wd          (csr_wd),
        .commit_valid    (commit_valid),
        .commit_pc       (commit_pc),
        .commit_instr    (commit_instr),
        .fwd_valid       (fwd_valid),
        .fwd_dst         (fwd_dst),
        .fwd_data        (fwd_data),
        .flush           (flush),
        .halted          (halted),
        .mcycle          (mcycle),
        .minstret        (minstret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  dst;
        logic        rf_wen;
        logic [63:0] result;
        logic        is_load;
        logic [1:0]  size;
        logic        uns;
        logic [2:0]  lo;
        logic [63:0] rdata;
        logic        csr_wen;
        logic [11:0] csr_addr;
        logic [63:0] csr_wdata;
        logic        trap;
        logic        halt;
    } ins_t;

    typedef struct {
        ins_t        i;
        logic        exp_wen;
        logic        exp_fwd;
        logic [63:0] exp_wd;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_ret  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic ins_t alu(input logic [63:0] pc, input logic [4:0] dst,
                                 input logic [63:0] result);
        ins_t x;
        x = '{pc: pc, dst: dst, rf_wen: 1'b1, result: result, is_load: 1'b0, size: 2'd0,
              uns: 1'b0, lo: 3'd0, rdata: 64'd0, csr_wen: 1'b0, csr_addr: 12'd0,
              csr_wdata: 64'd0, trap: 1'b0, halt: 1'b0};
        return x;
    endfunction

    function automatic ins_t ld(input logic [63:0] pc, input logic [4:0] dst,
                                input logic [1:0] size, input logic uns,
                                input logic [2:0] lo, input logic [63:0] rdata);
        ins_t x;
        x = alu(pc, dst, 64'hDEAD);
        x.is_load = 1'b1;
        x.size    = size;
        x.uns     = uns;
        x.lo      = lo;
        x.rdata   = rdata;
        return x;
    endfunction

    task automatic apply(input ins_t x, input logic valid);
        in_valid        = valid;
        in_pc           = x.pc;
        in_instr        = x.pc[31:0] + 32'h100;
        in_dst          = x.dst;
        in_rf_wen       = x.rf_wen;
        in_result       = x.result;
        in_is_load      = x.is_load;
        in_mem_size     = x.size;
        in_mem_unsigned = x.uns;
        in_mem_addr_lo  = x.lo;
        in_mem_rdata    = x.rdata;
        in_csr_wen      = x.csr_wen;
        in_csr_addr     = x.csr_addr;
        in_csr_wdata    = x.csr_wdata;
        in_trap         = x.trap;
        in_halt         = x.halt;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    vec_t vecs[11];
    ins_t t;

    initial begin
        vecs[0]  = '{alu(64'h1000, 5'd5, 64'h1234), 1'b1, 1'b1, 64'h1234};
        vecs[1]  = '{ld(64'h1004, 5'd6, 2'd0, 1'b0, 3'd3, 64'h0000_0000_80FF_0000),
                     1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80};
        vecs[2]  = '{ld(64'h1008, 5'd6, 2'd0, 1'b1, 3'd3, 64'h0000_0000_80FF_0000),
                     1'b1, 1'b1, 64'h80};
        vecs[3]  = '{ld(64'h100C, 5'd7, 2'd1, 1'b0, 3'd2, 64'h0000_0000_80FF_0000),
                     1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_80FF};
        vecs[4]  = '{ld(64'h1010, 5'd8, 2'd2, 1'b0, 3'd4, 64'h8765_4321_0000_0000),
                     1'b1, 1'b1, 64'hFFFF_FFFF_8765_4321};
        vecs[5]  = '{ld(64'h1014, 5'd8, 2'd2, 1'b1, 3'd4, 64'h8765_4321_0000_0000),
                     1'b1, 1'b1, 64'h8765_4321};
        vecs[6]  = '{ld(64'h1018, 5'd9, 2'd3, 1'b0, 3'd0, 64'h0123_4567_89AB_CDEF),
                     1'b1, 1'b1, 64'h0123_4567_89AB_CDEF};
        vecs[7]  = '{ld(64'h101C, 5'd9, 2'd0, 1'b0, 3'd7, 64'h7F00_0000_0000_0000),
                     1'b1, 1'b1, 64'h7F};
        vecs[8]  = '{alu(64'h1020, 5'd0, 64'h55), 1'b0, 1'b0, 64'h55};
        vecs[9]  = '{alu(64'h1024, 5'd9, 64'h66), 1'b0, 1'b0, 64'h66};
        vecs[9].i.rf_wen = 1'b0;
        vecs[10] = '{ld(64'h1028, 5'd31, 2'd1, 1'b1, 3'd6, 64'hFFEE_0000_0000_0000),
                     1'b1, 1'b1, 64'hFFEE};

        // Reset held for three edges.
        reset = 1'b0;
        stall = 1'b0;
        apply(alu(64'd0, 5'd0, 64'd0), 1'b0);
        repeat (3) tick();
        settle();
        check("rst_wen", {63'd0, wen}, 64'd0);
        check("rst_commit", {63'd0, commit_valid}, 64'd0);
        check("rst_fwd", {63'd0, fwd_valid}, 64'd0);
        check("rst_csr_wen", {63'd0, csr_wen}, 64'd0);
        check("rst_flush_halt", {62'd0, flush, halted}, 64'd0);
        check("rst_wd", wd, 64'd0);
        check("rst_mcycle", mcycle, 64'd0);
        check("rst_minstret", minstret, 64'd0);

        reset = 1'b1;
        settle();
        check("rel_in_ready", {63'd0, in_ready}, 64'd1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("rel_mcycle", mcycle, 64'(k));
        end

        for (int v = 0; v < 11; v++) begin
            apply(vecs[v].i, 1'b1);
            settle();
            check("vec_in_ready", {63'd0, in_ready}, 64'd1);
            tick();
            in_valid = 1'b0;
            settle();
            check("vec_commit", {63'd0, commit_valid}, 64'd1);
            check("vec_commit_pc", commit_pc, vecs[v].i.pc);
            check("vec_wen", {63'd0, wen}, {63'd0, vecs[v].exp_wen});
            check("vec_wa", {59'd0, wa}, {59'd0, vecs[v].i.dst});
            check("vec_wd", wd, vecs[v].exp_wd);
            check("vec_fwd_valid", {63'd0, fwd_valid}, {63'd0, vecs[v].exp_fwd});
            check("vec_minstret", minstret, 64'(exp_ret));
            tick();
            exp_ret++;
        end

        // Two-cycle stall holds W and blocks the commit.
        apply(alu(64'h2000, 5'd8, 64'hAA), 1'b1);
        settle();
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        repeat (2) begin
            settle();
            check("stall_in_ready", {63'd0, in_ready}, 64'd0);
            check("stall_commit", {63'd0, commit_valid}, 64'd0);
            check("stall_wen", {63'd0, wen}, 64'd0);
            check("stall_fwd", {59'd0, fwd_dst, fwd_valid}, {59'd0, 5'd8, 1'b1});
            check("stall_fwd_data", fwd_data, 64'hAA);
            tick();
        end
        stall = 1'b0;
        settle();
        check("unstall_commit", {62'd0, commit_valid, wen}, 64'd3);
        check("unstall_minstret", minstret, 64'(exp_ret));
        tick();
        exp_ret++;

        // Back-to-back: second instruction accepted on the first one's commit edge.
        apply(alu(64'h2100, 5'd10, 64'h10), 1'b1);
        settle();
        tick();
        apply(alu(64'h2104, 5'd11, 64'h11), 1'b1);
        settle();
        check("b2b_in_ready", {63'd0, in_ready}, 64'd1);
        check("b2b_wa1", {59'd0, wa}, 64'd10);
        tick();
        exp_ret++;
        in_valid = 1'b0;
        settle();
        check("b2b_wa2", {59'd0, wa}, 64'd11);
        check("b2b_wd2", wd, 64'h11);
        check("b2b_commit2", {63'd0, commit_valid}, 64'd1);
        tick();
        exp_ret++;
        settle();
        check("b2b_idle", {63'd0, commit_valid}, 64'd0);
        check("b2b_minstret", minstret, 64'(exp_ret));

        // CSR write to minstret alongside a GPR write.
        t = alu(64'h3000, 5'd7, 64'h5);
        t.csr_wen = 1'b1;
        t.csr_addr = 12'hB02;
        t.csr_wdata = 64'd100;
        apply(t, 1'b1);
        settle();
        tick();
        in_valid = 1'b0;
        settle();
        check("csr_wen_both", {62'd0, csr_wen, wen}, 64'd3);
        check("csr_wa", {52'd0, csr_wa}, 64'hB02);
        check("csr_wd", csr_wd, 64'd100);
        check("csr_gpr_wd", wd, 64'h5);
        tick();
        exp_ret = 100;
        settle();
        check("csr_minstret", minstret, 64'd100);

        t = alu(64'h3004, 5'd0, 64'h0);
        t.rf_wen = 1'b0;
        t.csr_wen = 1'b1;
        t.csr_addr = 12'hB00;
        t.csr_wdata = 64'd1000;
        apply(t, 1'b1);
        settle();
        tick();
        in_valid = 1'b0;
        tick();
        exp_ret++;
        settle();
        check("csr_mcycle", mcycle, 64'd1000);
        check("csr_minstret2", minstret, 64'(exp_ret));
        tick();
        check("csr_mcycle_inc", mcycle, 64'd1001);

        // Trap: writes suppressed, one flush cycle discards an instruction accepted alongside.
        t = alu(64'h4000, 5'd3, 64'h33);
        t.trap = 1'b1;
        t.csr_wen = 1'b1;
        t.csr_addr = 12'h300;
        apply(t, 1'b1);
        settle();
        tick();
        apply(alu(64'h4004, 5'd12, 64'hCC), 1'b1);
        settle();
        check("trap_commit", {63'd0, commit_valid}, 64'd1);
        check("trap_writes", {62'd0, csr_wen, wen}, 64'd0);
        tick();
        exp_ret++;
        in_valid = 1'b0;
        settle();
        check("trap_flush", {63'd0, flush}, 64'd1);
        check("trap_in_ready", {63'd0, in_ready}, 64'd0);
        check("trap_flush_commit", {63'd0, commit_valid}, 64'd0);
        tick();
        settle();
        check("post_flush", {62'd0, flush, in_ready}, 64'd1);
        check("post_flush_empty", {62'd0, commit_valid, fwd_valid}, 64'd0);
        check("trap_minstret", minstret, 64'(exp_ret));

        // Trap and halt together: trap wins.
        t = alu(64'h4100, 5'd3, 64'h33);
        t.trap = 1'b1;
        t.halt = 1'b1;
        apply(t, 1'b1);
        settle();
        tick();
        in_valid = 1'b0;
        tick();
        exp_ret++;
        settle();
        check("traphalt_state", {62'd0, flush, halted}, 64'd2);
        tick();
        settle();
        check("traphalt_after", {62'd0, flush, halted}, 64'd0);

        // Halt: its write happens, then no further commits.
        t = alu(64'h5000, 5'd4, 64'h77);
        t.halt = 1'b1;
        apply(t, 1'b1);
        settle();
        tick();
        in_valid = 1'b0;
        settle();
        check("halt_wen", {63'd0, wen}, 64'd1);
        check("halt_wd", wd, 64'h77);
        tick();
        exp_ret++;
        apply(alu(64'h5004, 5'd13, 64'h13), 1'b1);
        repeat (3) begin
            settle();
            check("halted", {61'd0, halted, in_ready, commit_valid}, 64'd4);
            tick();
        end
        check("halt_minstret", minstret, 64'(exp_ret));

        // Reset out of halt while stalled.
        in_valid = 1'b0;
        stall = 1'b1;
        reset = 1'b0;
        tick();
        settle();
        check("halt_reset", {62'd0, halted, flush}, 64'd0);
        check("halt_reset_cnt", mcycle | minstret, 64'd0);
        reset = 1'b1;
        stall = 1'b0;

        // Reset while an instruction is held by a stall drops it.
        apply(alu(64'h6000, 5'd14, 64'hEE), 1'b1);
        settle();
        tick();
        in_valid = 1'b0;
        stall = 1'b1;
        settle();
        check("mid_stall_fwd", {63'd0, fwd_valid}, 64'd1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        stall = 1'b0;
        settle();
        check("mid_stall_reset", {62'd0, fwd_valid, commit_valid}, 64'd0);
        check("mid_stall_ready", {63'd0, in_ready}, 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
